// File: rtl/offset_finder.sv
// rtl/offset_finder.sv - brute-force offset search of a Fibonacci LFSR state
//
// Purpose: steps a WIDTH-bit Fibonacci LFSR from SEED, one step per clock,
// until its state equals the latched data word. The number of steps taken
// is reported as the offset. If every non-zero state has been visited
// without a match, the all-ones offset is reported instead.
//
// Ports:
//   clk_96MHz   in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   polynomial  in   WIDTH-bit feedback tap mask (bit i set = state bit i is a tap)
//   data        in   WIDTH-bit LFSR state to locate
//   enable      in   level; high requests/holds a search, low aborts or clears
//   offset      out  steps from SEED to data, all-ones when not found
//   ready       out  high while offset is valid for the current request
module offset_finder #(
  parameter int               WIDTH = 17,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_96MHz,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] polynomial,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  output logic [WIDTH-1:0] offset,
  output logic             ready
);

  // 2^WIDTH - 2: the count at which all 2^WIDTH - 1 non-zero states have been compared
  localparam logic [WIDTH-1:0] COUNT_LIMIT = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] NOT_FOUND   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] offset_q, offset_d;
  logic             ready_q, ready_d;

  logic             fb;
  logic [WIDTH-1:0] lfsr_next;
  logic             hit;
  logic             exhausted;

  assign fb        = ^(lfsr_q & poly_q);
  assign lfsr_next = {lfsr_q[WIDTH-2:0], fb};
  assign hit       = (lfsr_q == data_q);
  assign exhausted = (count_q == COUNT_LIMIT);

  // State register
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= IDLE;
      poly_q   <= '0;
      data_q   <= '0;
      lfsr_q   <= '0;
      count_q  <= '0;
      offset_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      poly_q   <= poly_d;
      data_q   <= data_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (enable) fsm_d = SEARCH;
      end
      SEARCH: begin
        if (!enable)               fsm_d = IDLE;
        else if (hit || exhausted) fsm_d = DONE;
      end
      DONE: begin
        if (!enable) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    poly_d   = poly_q;
    data_d   = data_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    offset_d = offset_q;
    ready_d  = ready_q;
    case (fsm_q)
      IDLE: begin
        ready_d = 1'b0;
        // Inputs are captured only here, so later changes cannot disturb a search
        if (enable) begin
          poly_d  = polynomial;
          data_d  = data;
          lfsr_d  = SEED;
          count_d = '0;
        end
      end
      SEARCH: begin
        if (!enable) begin
          ready_d = 1'b0;
        end else if (hit) begin
          offset_d = count_q;
          ready_d  = 1'b1;
        end else if (exhausted) begin
          offset_d = NOT_FOUND;
          ready_d  = 1'b1;
        end else begin
          lfsr_d  = lfsr_next;
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        ready_d = enable;
      end
      default: ready_d = 1'b0;
    endcase
  end

  assign offset = offset_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_offset_finder.sv
// tb/tb_offset_finder.sv - scoreboard bench for offset_finder
module tb_offset_finder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [16:0] poly = '0, data = '0, offset;
  logic        en = 1'b0, ready;
  logic [7:0]  s_poly = '0, s_data = '0, s_offset;
  logic        s_en = 1'b0, s_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] sb[$];
  logic [16:0] sb_s[$];
  logic rdy_prev = 1'b0, s_rdy_prev = 1'b0;

  always #5 clk = ~clk;

  offset_finder dut (
    .clk_96MHz(clk), .reset_n(reset_n), .polynomial(poly), .data(data),
    .enable(en), .offset(offset), .ready(ready)
  );

  // Narrow instance so that the exhaustive not-found path runs in a few hundred cycles
  offset_finder #(.WIDTH(8)) dut_s (
    .clk_96MHz(clk), .reset_n(reset_n), .polynomial(s_poly), .data(s_data),
    .enable(s_en), .offset(s_offset), .ready(s_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: walk the sequence from seed 1 and return the first position of d
  function automatic logic [16:0] model(input int w, input logic [16:0] p, input logic [16:0] d);
    int mask = (1 << w) - 1;
    int s = 1;
    for (int k = 0; k < mask; k++) begin
      if (s == int'(d)) return 17'(k);
      s = ((s << 1) | ($countones(s & int'(p)) & 1)) & mask;
    end
    return 17'(mask);
  endfunction

  function automatic logic [16:0] advance(input logic [16:0] p, input int k);
    int s = 1;
    for (int i = 0; i < k; i++)
      s = ((s << 1) | ($countones(s & int'(p)) & 1)) & 32'h1FFFF;
    return 17'(s);
  endfunction

  // Monitors: every rising ready must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ready && !rdy_prev) begin
      if (sb.size() == 0) check("unexpected_ready", {15'd0, offset}, 32'hFFFF_FFFF);
      else check("offset", {15'd0, offset}, {15'd0, sb.pop_front()});
    end
    rdy_prev = ready;
  end

  always @(negedge clk) begin
    if (s_ready && !s_rdy_prev) begin
      if (sb_s.size() == 0) check("unexpected_ready_w8", {24'd0, s_offset}, 32'hFFFF_FFFF);
      else check("offset_w8", {24'd0, s_offset}, {15'd0, sb_s.pop_front()});
    end
    s_rdy_prev = s_ready;
  end

  task automatic run_big(input logic [16:0] p, input logic [16:0] d, input bit lat,
                         input bit scramble, input int hold);
    logic [16:0] exp;
    int edges, limit;
    exp = model(17, p, d);
    limit = (exp == 17'h1FFFF) ? 131080 : int'(exp) + 8;
    @(negedge clk);
    poly = p; data = d; en = 1'b1;
    sb.push_back(exp);
    edges = 0;
    do begin
      @(posedge clk); edges++; #1;
      if (scramble && edges == 1) begin poly = 17'($urandom); data = 17'($urandom); end
    end while (!ready && edges < limit);
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    else if (lat) check("latency", edges, (exp == 17'h1FFFF) ? 131072 : int'(exp) + 2);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("ready_held", {31'd0, ready}, 32'd1);
    end
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check("ready_clear", {31'd0, ready}, 32'd0);
  endtask

  task automatic run_small(input logic [7:0] p, input logic [7:0] d);
    logic [16:0] exp;
    int edges;
    exp = model(8, {9'd0, p}, {9'd0, d});
    @(negedge clk);
    s_poly = p; s_data = d; s_en = 1'b1;
    sb_s.push_back(exp);
    edges = 0;
    do begin @(posedge clk); edges++; #1; end while (!s_ready && edges < 300);
    if (!s_ready) check("ready_timeout_w8", 32'd0, 32'd1);
    else check("latency_w8", edges, (exp == 17'hFF) ? 256 : int'(exp) + 2);
    @(negedge clk); s_en = 1'b0;
    @(posedge clk); #1;
    check("ready_clear_w8", {31'd0, s_ready}, 32'd0);
  endtask

  initial begin
    logic [16:0] rp;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_offset", {15'd0, offset}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;

    // Seed hit and the first few sequence positions
    run_big(17'h17e04, 17'h00001, 1, 0, 2);
    run_big(17'h17e04, 17'h00002, 1, 0, 0);
    run_big(17'h17e04, 17'h00004, 1, 0, 0);
    run_big(17'h17e04, 17'h00009, 1, 0, 0);
    run_big(17'h17e04, 17'h00012, 1, 0, 0);

    // Long search, then re-arm with another polynomial
    run_big(17'h17e04, 17'h189d5, 1, 0, 5);
    run_big(17'h1d258, 17'h042b2, 1, 0, 0);

    // Random polynomials, data a short random distance into the sequence
    for (int t = 0; t < 4; t++) begin
      rp = 17'($urandom) | 17'h10000;
      run_big(rp, advance(rp, $urandom_range(0, 300)), 1, 0, 0);
    end

    // Inputs changed after load must not affect the result
    run_big(17'h17e04, 17'h00012, 1, 1, 0);

    // Abort: no result may appear
    @(negedge clk); poly = 17'h17e04; data = 17'h00000; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("abort_ready_low", {31'd0, ready}, 32'd0);
    end
    @(negedge clk); en = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort_ready_idle", {31'd0, ready}, 32'd0);
    run_big(17'h17e04, 17'h00009, 1, 0, 0);

    // Exhaustive search on the narrow instance: zero, random, non-maximal
    run_small(8'hB8, 8'h00);
    run_small(8'h03, 8'h80);
    for (int t = 0; t < 8; t++) run_small(8'($urandom), 8'($urandom));

    // Asynchronous reset between edges, mid-search
    @(negedge clk); poly = 17'h17e04; data = 17'h00000; en = 1'b1;
    repeat (40) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_ready", {31'd0, ready}, 32'd0);
    check("async_offset", {15'd0, offset}, 32'd0);
    en = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    run_big(17'h17e04, 17'h00004, 1, 0, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size() + sb_s.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
